// File: rtl/fetch_pkg.sv
// Shared fetch-stage constants: redirect kinds, im window defaults and the PC window check.
package fetch_pkg;

  localparam logic [1:0] KIND_BR  = 2'd0;
  localparam logic [1:0] KIND_J   = 2'd1;
  localparam logic [1:0] KIND_JR  = 2'd2;
  localparam logic [1:0] KIND_RSV = 2'd3;

  localparam logic [31:0] DEF_RESET_PC = 32'h0040_0000;
  localparam int unsigned DEF_IM_AW    = 11;
  localparam int unsigned DEF_IM_DEPTH = 2048;

  // Word-aligned and inside [base, base + win_bytes); the offset compare also rejects wrap-around.
  function automatic logic addr_ok(input logic [31:0] addr, input logic [31:0] base,
                                   input logic [31:0] win_bytes);
    logic [31:0] off;
    off = addr - base;
    return (addr[1:0] == 2'b00) && (addr >= base) && (off < win_bytes);
  endfunction

endpackage

// File: rtl/if_npc.sv
// Next-PC target computation for BR/J/JR redirects, plus the im window/alignment check.
module if_npc
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter int unsigned IM_DEPTH = DEF_IM_DEPTH
) (
  input  logic [1:0]  kind_i,
  input  logic [31:0] base_i,
  input  logic [15:0] imm16_i,
  input  logic [25:0] idx26_i,
  input  logic [31:0] reg_i,
  output logic [31:0] target_o,
  output logic        bad_o
);

  localparam logic [31:0] WinBytes = 32'(4 * IM_DEPTH);

  logic [31:0] base4;

  always_comb begin
    base4    = base_i + 32'd4;
    target_o = '0;
    case (kind_i)
      KIND_BR: target_o = base4 + {{14{imm16_i[15]}}, imm16_i, 2'b00};
      KIND_J:  target_o = {base4[31:28], idx26_i, 2'b00};
      KIND_JR: target_o = reg_i;
      default: target_o = '0;
    endcase
    bad_o = !addr_ok(target_o, RESET_PC, WinBytes);
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC, one-entry fetch register with valid/ready to decode,
// redirect/flush handling and a sticky fault on a bad PC.
module if_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter int unsigned IM_AW    = DEF_IM_AW,
  parameter int unsigned IM_DEPTH = DEF_IM_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  output logic [IM_AW-1:0] im_addr,
  input  logic [31:0]      im_inst,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_pc4,
  input  logic             redir_valid,
  input  logic [1:0]       redir_kind,
  input  logic [31:0]      redir_base,
  input  logic [15:0]      redir_imm16,
  input  logic [25:0]      redir_idx26,
  input  logic [31:0]      redir_reg,
  output logic             fault
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] opc_q, opc_d;
  logic [31:0] opc4_q, opc4_d;
  logic        valid_q, valid_d;
  logic        fault_q, fault_d;

  logic [31:0] redir_tgt;
  logic        redir_bad;
  logic [31:0] pc_cur;
  logic        pc_bad;
  logic [31:0] pc_off;
  logic        redir_take;
  logic        adv;

  if_npc #(
    .RESET_PC (RESET_PC),
    .IM_DEPTH (IM_DEPTH)
  ) u_redir_npc (
    .kind_i   (redir_kind),
    .base_i   (redir_base),
    .imm16_i  (redir_imm16),
    .idx26_i  (redir_idx26),
    .reg_i    (redir_reg),
    .target_o (redir_tgt),
    .bad_o    (redir_bad)
  );

  // Same check reused for the sequential PC: a JR "redirect" to pc_q passes it straight through.
  if_npc #(
    .RESET_PC (RESET_PC),
    .IM_DEPTH (IM_DEPTH)
  ) u_pc_chk (
    .kind_i   (KIND_JR),
    .base_i   (32'd0),
    .imm16_i  (16'd0),
    .idx26_i  (26'd0),
    .reg_i    (pc_q),
    .target_o (pc_cur),
    .bad_o    (pc_bad)
  );

  assign pc_off  = pc_cur - RESET_PC;
  assign im_addr = IM_AW'(pc_off >> 2);

  assign redir_take = redir_valid && (redir_kind != KIND_RSV);
  assign adv        = !fault_q && (!valid_q || out_ready);

  always_comb begin
    pc_d    = pc_q;
    inst_d  = inst_q;
    opc_d   = opc_q;
    opc4_d  = opc4_q;
    valid_d = valid_q;
    fault_d = fault_q;
    if (redir_take) begin
      // Flush wins over a same-cycle accept; the target still loads even if it is bad.
      pc_d    = redir_tgt;
      valid_d = 1'b0;
      fault_d = fault_q | redir_bad;
    end else if (adv) begin
      if (pc_bad) begin
        fault_d = 1'b1;
        valid_d = 1'b0;
      end else begin
        inst_d  = im_inst;
        opc_d   = pc_q;
        opc4_d  = pc_q + 32'd4;
        valid_d = 1'b1;
        pc_d    = pc_q + 32'd4;
      end
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      inst_q  <= '0;
      opc_q   <= '0;
      opc4_q  <= '0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      opc_q   <= opc_d;
      opc4_q  <= opc4_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
    end
  end

  assign out_valid = valid_q;
  assign out_inst  = inst_q;
  assign out_pc    = opc_q;
  assign out_pc4   = opc4_q;
  assign fault     = fault_q;

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: directed scenarios plus randomized traffic against a
// cycle-level reference model of the fetch stage.
module tb_if_fetch;

  localparam logic [31:0] RESET_PC = 32'h0040_0000;
  localparam int unsigned IM_AW    = 11;
  localparam int unsigned IM_DEPTH = 2048;

  logic             clk = 1'b0;
  logic             rst;
  logic [IM_AW-1:0] im_addr;
  logic [31:0]      im_inst;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_inst;
  logic [31:0]      out_pc;
  logic [31:0]      out_pc4;
  logic             redir_valid;
  logic [1:0]       redir_kind;
  logic [31:0]      redir_base;
  logic [15:0]      redir_imm16;
  logic [25:0]      redir_idx26;
  logic [31:0]      redir_reg;
  logic             fault;

  logic [31:0] mem [IM_DEPTH];

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Reference model state
  bit          m_known = 1'b0;
  logic [31:0] m_pc, m_inst, m_opc, m_opc4;
  bit          m_valid, m_fault;

  always #5 clk = ~clk;

  assign im_inst = mem[im_addr];

  if_fetch #(
    .RESET_PC (RESET_PC),
    .IM_AW    (IM_AW),
    .IM_DEPTH (IM_DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .im_addr     (im_addr),
    .im_inst     (im_inst),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_inst    (out_inst),
    .out_pc      (out_pc),
    .out_pc4     (out_pc4),
    .redir_valid (redir_valid),
    .redir_kind  (redir_kind),
    .redir_base  (redir_base),
    .redir_imm16 (redir_imm16),
    .redir_idx26 (redir_idx26),
    .redir_reg   (redir_reg),
    .fault       (fault)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit in_win(input logic [31:0] a);
    longint unsigned av, lo, hi;
    av = {32'd0, a};
    lo = {32'd0, RESET_PC};
    hi = lo + 4 * IM_DEPTH;
    return (a % 4 == 0) && (av >= lo) && (av < hi);
  endfunction

  function automatic logic [31:0] tgt_of(input logic [1:0] k, input logic [31:0] base,
                                         input logic [15:0] imm, input logic [25:0] idx,
                                         input logic [31:0] rg);
    logic [31:0] simm;
    simm = 32'($signed(imm));
    case (k)
      2'd0:    return base + 32'd4 + simm * 32'd4;
      2'd1:    return ((base + 32'd4) & 32'hF000_0000) + {6'd0, idx} * 32'd4;
      default: return rg;
    endcase
  endfunction

  // Compare at the falling edge, advance the model over the rising edge, settle 1 time unit.
  task automatic tick();
    logic [31:0] n_pc, n_inst, n_opc, n_opc4;
    bit          n_valid, n_fault;
    @(negedge clk);
    if (m_known) begin
      check("out_valid", 32'(out_valid), 32'(m_valid));
      check("fault", 32'(fault), 32'(m_fault));
      check("out_inst", out_inst, m_inst);
      check("out_pc", out_pc, m_opc);
      check("out_pc4", out_pc4, m_opc4);
      if (!m_fault) check("im_addr", 32'(im_addr), ((m_pc - RESET_PC) / 4) % IM_DEPTH);
    end
    n_pc = m_pc; n_inst = m_inst; n_opc = m_opc; n_opc4 = m_opc4;
    n_valid = m_valid; n_fault = m_fault;
    if (rst) begin
      n_pc = RESET_PC; n_inst = 0; n_opc = 0; n_opc4 = 0; n_valid = 0; n_fault = 0;
    end else if (redir_valid && redir_kind != 2'd3) begin
      n_pc    = tgt_of(redir_kind, redir_base, redir_imm16, redir_idx26, redir_reg);
      n_valid = 0;
      if (!in_win(n_pc)) n_fault = 1;
    end else if (!m_fault && (!m_valid || out_ready)) begin
      if (!in_win(m_pc)) begin
        n_fault = 1;
        n_valid = 0;
      end else begin
        n_inst  = mem[(m_pc - RESET_PC) / 4];
        n_opc   = m_pc;
        n_opc4  = m_pc + 4;
        n_valid = 1;
        n_pc    = m_pc + 4;
      end
    end else if (m_valid && out_ready) begin
      n_valid = 0;
    end
    @(posedge clk);
    #1;
    m_pc = n_pc; m_inst = n_inst; m_opc = n_opc; m_opc4 = n_opc4;
    m_valid = n_valid; m_fault = n_fault;
    if (rst) m_known = 1'b1;
  endtask

  task automatic redirect(input logic [1:0] k, input logic [31:0] base, input logic [15:0] imm,
                          input logic [25:0] idx, input logic [31:0] rg);
    redir_valid = 1'b1; redir_kind = k; redir_base = base;
    redir_imm16 = imm; redir_idx26 = idx; redir_reg = rg;
    tick();
    redir_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] held_pc;
    int          off;
    for (int i = 0; i < int'(IM_DEPTH); i++) mem[i] = $urandom;
    for (int i = 0; i < 4; i++) mem[i] = 32'h2008_0001 + 32'(i);

    rst = 1'b1; out_ready = 1'b1; redir_valid = 1'b0; redir_kind = 2'd0;
    redir_base = 0; redir_imm16 = 0; redir_idx26 = 0; redir_reg = 0;
    tick();
    tick();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_out_pc", out_pc, 32'd0);
    check("rst_im_addr", 32'(im_addr), 32'd0);

    // Straight-line fetch
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("seq_pc", out_pc, RESET_PC + 32'(4 * i));
      check("seq_inst", out_inst, 32'h2008_0001 + 32'(i));
      check("seq_im_addr", 32'(im_addr), 32'(i + 1));
    end

    // Stall: held for 3 edges, then resume with the next word
    out_ready = 1'b0;
    held_pc = out_pc;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_pc", out_pc, held_pc);
      check("stall_im_addr", 32'(im_addr), 32'd4);
    end
    out_ready = 1'b1;
    tick();
    check("resume_pc", out_pc, held_pc + 32'd4);

    // BR backwards, flushing a valid entry that decode is accepting
    redirect(2'd0, 32'h0040_0008, 16'hFFFE, 26'd0, 32'd0);
    check("br_flush", 32'(out_valid), 32'd0);
    tick();
    check("br_valid", 32'(out_valid), 32'd1);
    check("br_pc", out_pc, 32'h0040_0004);

    redirect(2'd1, 32'h0040_0004, 16'd0, 26'h010_0010, 32'd0);
    tick();
    check("j_pc", out_pc, 32'h0040_0040);

    // Reserved kind behaves as no redirect
    held_pc = out_pc;
    redirect(2'd3, 32'h0040_0004, 16'd0, 26'd0, 32'h0040_1000);
    check("rsv_pc", out_pc, held_pc + 32'd4);

    // Faults: misaligned, above window, below window; last word fetches then faults
    redirect(2'd2, 32'd0, 16'd0, 26'd0, 32'h0040_0006);
    check("mis_fault", 32'(fault), 32'd1);
    tick(); tick();
    check("mis_sticky", 32'(fault), 32'd1);
    check("mis_valid", 32'(out_valid), 32'd0);
    do_reset();
    check("clr_fault", 32'(fault), 32'd0);
    redirect(2'd2, 32'd0, 16'd0, 26'd0, 32'h0040_2000);
    check("hi_fault", 32'(fault), 32'd1);
    do_reset();
    tick();
    check("restart_pc", out_pc, RESET_PC);
    redirect(2'd2, 32'd0, 16'd0, 26'd0, 32'h003F_FFFC);
    check("lo_fault", 32'(fault), 32'd1);
    do_reset();
    redirect(2'd2, 32'd0, 16'd0, 26'd0, 32'h0040_1FFC);
    tick();
    check("last_pc", out_pc, 32'h0040_1FFC);
    check("last_fault", 32'(fault), 32'd0);
    tick();
    check("past_fault", 32'(fault), 32'd1);
    check("past_valid", 32'(out_valid), 32'd0);
    do_reset();

    // Reset beats a same-cycle redirect
    tick(); tick();
    rst = 1'b1;
    redirect(2'd2, 32'd0, 16'd0, 26'd0, 32'h0040_0100);
    rst = 1'b0;
    check("rst_redir_valid", 32'(out_valid), 32'd0);
    check("rst_redir_im_addr", 32'(im_addr), 32'd0);
    tick();
    check("rst_redir_pc", out_pc, RESET_PC);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst         = ($urandom_range(0, 63) == 0) || (m_fault && $urandom_range(0, 7) == 0);
      out_ready   = $urandom_range(0, 3) != 0;
      redir_valid = $urandom_range(0, 7) == 0;
      redir_kind  = 2'($urandom_range(0, 3));
      redir_base  = m_valid ? m_opc : m_pc;
      off         = int'($urandom_range(0, 1200)) - 600;
      redir_imm16 = 16'(off);
      redir_idx26 = 26'((RESET_PC >> 2) + $urandom_range(0, 2100));
      redir_reg   = RESET_PC + 32'(4 * $urandom_range(0, 2100));
      if ($urandom_range(0, 7) == 0) redir_reg = redir_reg + 32'($urandom_range(1, 3));
      if ($urandom_range(0, 31) == 0) redir_reg = $urandom;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
